// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer and its synchronizer.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing a single asynchronous input into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: clean pressed level plus one-cycle press, release and
// auto-repeat pulses, all from one shared counter and registered outputs.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic             btnSync;
  btn_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             hold_q;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btnSync)
  );

  // The counter is reloaded on every state change so each debounce window
  // and each hold period starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      hold_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btnSync) begin
            state_q <= WAIT_PRESS;
            cnt_q   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!btnSync) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!btnSync) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            hold_q <= 1'b1;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_RELEASE: begin
          // A release glitch drops back to PRESSED with a fresh hold period.
          if (btnSync) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign hold  = hold_q;

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces one asynchronous mechanical push-button input and converts it into a clean level plus single-cycle event pulses (press, release, long-press auto-repeat). Sits directly upstream of the lab's registered datapath (D flip-flop banks, counters, shift registers). Its `rise`, `fall` and `hold` outputs drive the `d` or enable inputs of those stages, so a single physical press advances them exactly once.

## Interface

Parameters:
- `STABLE_CYCLES`, default 1_000_000: consecutive synchronized-stable cycles required to accept a level change (10 ms at 100 MHz); must be ≥ 2.
- `HOLD_CYCLES`, default 50_000_000: cycles between auto-repeat `hold` pulses while pressed (0.5 s at 100 MHz); must be ≥ 2.

Ports:
- `clk`  in  1: single system clock; all state is on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low; no other reset exists.
- `btn_in`  in  1: raw button, asynchronous to `clk`, may bounce.
- `level`  out  1: debounced button state, 1 = pressed.
- `rise`  out  1: one-cycle pulse on accepted press.
- `fall`  out  1: one-cycle pulse on accepted release.
- `hold`  out  1: one-cycle pulse every `HOLD_CYCLES` while pressed.

## Operation

- `btn_in` passes through a 2-flop synchronizer (`s1`, `s2`). The FSM looks only at `s2`.
- One shared counter `cnt` has width `CNT_W = $clog2(max(STABLE_CYCLES, HOLD_CYCLES))`. It never wraps past its terminal value; it is reloaded to 0 on every state change.

FSM states and transitions:
- IDLE: waits for `s2 = 1`, then goes to WAIT_PRESS with `cnt <= 0`.
- WAIT_PRESS:
  - If `s2 = 0`, return to IDLE with no outputs.
  - Else if `cnt == STABLE_CYCLES-1`, go to PRESSED; `level <= 1`, `rise <= 1`, `cnt <= 0`.
  - Else `cnt++`.
- PRESSED:
  - If `s2 = 0`, go to WAIT_RELEASE with `cnt <= 0`.
  - Else if `cnt == HOLD_CYCLES-1`, `hold <= 1` and `cnt <= 0` (auto-repeat).
  - Else `cnt++`.
- WAIT_RELEASE:
  - If `s2 = 1`, return to PRESSED with `cnt <= 0`, no pulse; the hold period restarts.
  - Else if `cnt == STABLE_CYCLES-1`, go to IDLE; `level <= 0`, `fall <= 1`.
  - Else `cnt++`.

Output rules:
- All outputs are registered.
- `rise`, `fall` and `hold` are high for exactly one cycle and mutually exclusive.
- `hold` never asserts outside PRESSED.

## Timing

- Reset (`rst_n = 0`, asynchronous):
  - `s1`, `s2`, `cnt` = 0; state = IDLE.
  - `level`, `rise`, `fall`, `hold` = 0, taking effect immediately without waiting for a clock edge.
- A button already held when reset releases is a new press and gets full debounce; no `rise` is skipped or pre-asserted.
- Press latency: `btn_in` high first sampled at edge 0 → `level`/`rise` high after edge `STABLE_CYCLES+2`. Release latency is identical for `fall`.
- First `hold` comes `HOLD_CYCLES` edges after entering PRESSED, then every `HOLD_CYCLES` edges after that.
- Bounce inside a WAIT_* window restarts the debounce: the FSM returns to the previous stable state, and `cnt` starts again from 0 on the next entry.
- Reset asserted mid-press or mid-WAIT aborts the in-progress event. No pulse is emitted, and outputs read 0 the moment reset asserts.

## Structure

- Shared package `btn_pkg`:
  - state enum `btn_state_t` = {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE}, 2-bit binary.
  - helper function `cnt_width(a, b)` returning `$clog2` of the max.
- Sub-module `sync_2ff`: ports `clk`, `rst_n` (async active-low), `d`, `q`; both flops reset to 0. The datapath team reuses it for other asynchronous inputs.
- The top level holds the FSM, the counter and the output registers.

## Test plan

All scenarios use `STABLE_CYCLES = 4`, `HOLD_CYCLES = 8`, and a free-running `clk`.
1. Async reset: press accepted (`level = 1`), then pull `rst_n` low between edges → all outputs 0 before the next edge. Release reset with `btn_in = 1` → `rise` again 6 edges later.
2. Clean press: `btn_in` 0→1 at edge 0, held 12 cycles → `level` and `rise` high after edge 6; `rise` low after edge 7; `fall` and `hold` stay 0.
3. Bounce: `btn_in` pattern 1,1,1,0,1,1,1,1 from edge 0 → no `rise` from the first burst; a single `rise` only after 4 stable `s2` cycles of the second burst.
4. Long press: held 30 cycles after `rise` at edge 6 → `hold` pulses after edges 14, 22 and 30; `level` stays 1 throughout.
5. Release: from PRESSED, `btn_in` low at edge N → `level` 0 and `fall` high after edge N+6; no `hold` thereafter.
6. Release glitch: from PRESSED, `btn_in` low 2 cycles, then high → state back to PRESSED; no `fall`, no `rise`; next `hold` comes 8 edges after re-entry.
